// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions: reset PC, opcode field position,
//               opcode values used by fetch and control, fetch FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Opcode field position inside a 32-bit instruction word
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    // Opcode values shared with the control unit
    localparam logic [5:0] OPC_RTYPE = 6'd0;
    localparam logic [5:0] OPC_LW    = 6'd35;
    localparam logic [5:0] OPC_SW    = 6'd43;
    localparam logic [5:0] OPC_BEQ   = 6'd4;
    localparam logic [5:0] OPC_J     = 6'd2;

    // Fetch unit states: RUN issues requests, FLUSH drains stale responses
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    // Extract the opcode field of an instruction word
    function automatic logic [5:0] get_opcode(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buf.sv
// ============================================================================
// Module      : fetch_buf
// Description : Synchronous FIFO holding {pc, instr} entries. Registered
//               head; push and pop in the same cycle are allowed when full;
//               clear empties the FIFO in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]                wr_ptr_q;
    logic [AW-1:0]                rd_ptr_q;
    logic [CW-1:0]                count_q;
    logic [DEPTH-1:0][WIDTH-1:0]  w_entries;
    logic                         w_push;
    logic                         w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

    // A push into a full FIFO is only taken when the head leaves this cycle
    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    // Pointer and occupancy tracking; clear wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_q;

        // Storage slot, written when the write pointer selects it
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_q <= '0;
            end else if (w_push && !clear_i && (wr_ptr_q == AW'(gi))) begin
                entry_q <= wdata_i;
            end
        end

        assign w_entries[gi] = entry_q;
    end

    assign rdata_o = w_entries[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch front end. Issues word fetches over a
//               req/gnt/rvalid memory interface, buffers returned words with
//               their PC and presents them to decode via valid/ready.
//               Redirects clear the buffer and drop in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [5:0]  opCode,
    output logic [31:0] instrPc,
    input  logic        instrReady,
    input  logic        redirect,
    input  logic [31:0] redirectPc
);

    localparam int            AW        = $clog2(BUF_DEPTH);
    localparam int            CW        = AW + 1;
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(BUF_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic [63:0]   w_head;
    logic [CW:0]   w_inflight;
    logic          w_issue;
    logic          w_rsp;
    logic          w_keep;
    logic          w_pop;
    logic [31:0]   w_redirect_pc;
    logic          w_unused_ok;

    // Low address bits of the redirect target are forced to zero
    assign w_redirect_pc = {redirectPc[31:2], 2'b00};
    assign w_unused_ok   = &{1'b0, redirectPc[1:0]};

    // Buffered words plus in-flight requests may never exceed the depth
    assign w_inflight = {1'b0, w_count} + {1'b0, outstanding_q};

    // Request is held off while in reset so nothing issues before release
    assign imemReq  = rst_n & (state_q == ST_RUN) & (w_inflight < DEPTH_LIM) & ~redirect;
    assign imemAddr = pc_q;
    assign w_issue  = imemReq & imemGnt;

    // Responses with nothing outstanding are stray and ignored
    assign w_rsp  = imemRvalid & (outstanding_q != '0);
    assign w_keep = w_rsp & (drop_cnt_q == '0) & ~redirect;

    assign instrValid = ~w_empty;
    assign w_pop      = instrValid & instrReady;
    assign instr      = w_head[31:0];
    assign instrPc    = w_head[63:32];
    assign opCode     = get_opcode(w_head[31:0]);

    fetch_buf #(
        .WIDTH (64),
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_keep),
        .wdata_i ({rsp_pc_q, imemRdata}),
        .pop_i   (w_pop),
        .clear_i (redirect),
        .rdata_o (w_head),
        .empty_o (w_empty),
        .full_o  (w_full),
        .count_o (w_count)
    );

    // Next fetch PC, next response PC and in-flight request count
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        case ({w_issue, w_rsp})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
        if (redirect) begin
            // Every in-flight response is dropped, so the next kept one
            // belongs to the first fetch at the new target
            pc_d     = w_redirect_pc;
            rsp_pc_d = w_redirect_pc;
        end else begin
            if (w_issue) begin
                pc_d = pc_q + 32'd4;
            end
            if (w_keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
        end
    end

    // FSM next state and stale-response drop counter
    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = outstanding_d;
            state_d    = (outstanding_d != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            if (w_rsp && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if ((state_q == ST_FLUSH) && (drop_cnt_d == '0)) begin
                state_d = ST_RUN;
            end
        end
    end

    // State register for PC tracking, counters and FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imemRvalid && (outstanding_q == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_keep && w_full && !w_pop));
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic [31:0] instr;
    logic [5:0]  opCode;
    logic [31:0] instrPc;
    logic        instrReady;
    logic        redirect;
    logic [31:0] redirectPc;

    int tests_run;
    int fails;

    logic        gnt_en;
    logic        rsp_en;
    logic [31:0] pend_q[$];
    logic [31:0] iss_log[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_instr[$];

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemGnt    (imemGnt),
        .imemRvalid (imemRvalid),
        .imemRdata  (imemRdata),
        .instrValid (instrValid),
        .instr      (instr),
        .opCode     (opCode),
        .instrPc    (instrPc),
        .instrReady (instrReady),
        .redirect   (redirect),
        .redirectPc (redirectPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C01_0000;
        if (a == 32'h4) return 32'hAC02_0004;
        return a ^ 32'h1234_0000;
    endfunction

    // One clock cycle: drive memory side, log issue/accept, advance past edge
    task automatic tick();
        logic        iss;
        logic        acc;
        logic [31:0] a;
        logic [31:0] dummy;
        imemGnt = gnt_en;
        if (rsp_en && pend_q.size() > 0) begin
            imemRvalid = 1'b1;
            imemRdata  = mem_word(pend_q[0]);
        end else begin
            imemRvalid = 1'b0;
            imemRdata  = 32'h0;
        end
        #1;
        iss = imemReq & imemGnt;
        a   = imemAddr;
        acc = instrValid & instrReady;
        if (acc) begin
            acc_pc.push_back(instrPc);
            acc_instr.push_back(instr);
        end
        @(posedge clk);
        if (imemRvalid) dummy = pend_q.pop_front();
        if (iss) begin
            pend_q.push_back(a);
            iss_log.push_back(a);
        end
        #1;
        imemRvalid = 1'b0;
    endtask

    task automatic clear_logs();
        pend_q.delete();
        iss_log.delete();
        acc_pc.delete();
        acc_instr.delete();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        imemGnt    = 1'b0;
        imemRvalid = 1'b0;
        imemRdata  = 32'h0;
        instrReady = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        gnt_en     = 1'b0;
        rsp_en     = 1'b0;
        clear_logs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = 32'h0;
        instrReady = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
        gnt_en = 1'b0; rsp_en = 1'b0;
        #2;
        tests_run++; if (imemReq !== 1'b0) begin fails++; $display("FAIL reset_req: got %0b want 0", imemReq); end
        tests_run++; if (imemAddr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", imemAddr); end
        tests_run++; if (instrValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", instrValid); end
        tests_run++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr); end
        tests_run++; if (opCode !== 6'd0) begin fails++; $display("FAIL reset_opcode: got %0d want 0", opCode); end
        tests_run++; if (instrPc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", instrPc); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        tests_run++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin fails++; $display("FAIL first_req: got req=%0b addr=%h want 1/0", imemReq, imemAddr); end
    endtask

    task automatic test_sequential();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; instrReady = 1'b1;
        tick();
        tests_run++; if (instrValid !== 1'b0) begin fails++; $display("FAIL seq_latency_early: got valid=%0b want 0", instrValid); end
        tick();
        tests_run++; if (instrValid !== 1'b1 || instrPc !== 32'h0 || instr !== 32'h8C01_0000) begin
            fails++; $display("FAIL seq_first_word: got v=%0b pc=%h ins=%h want 1/0/8c010000", instrValid, instrPc, instr); end
        repeat (14) tick();
        tests_run++; if (iss_log.size() < 6) begin fails++; $display("FAIL seq_issue_count: got %0d want >=6", iss_log.size()); end
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (i >= iss_log.size() || iss_log[i] !== 32'(4 * i)) begin
                fails++; $display("FAIL seq_addr[%0d]: got %h want %h", i, (i < iss_log.size()) ? iss_log[i] : 32'hx, 32'(4 * i)); end
        end
        tests_run++; if (acc_pc.size() < 4) begin fails++; $display("FAIL seq_accept_count: got %0d want >=4", acc_pc.size()); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i >= acc_pc.size() || acc_pc[i] !== 32'(4 * i) || acc_instr[i] !== mem_word(32'(4 * i))) begin
                fails++; $display("FAIL seq_accept[%0d]: got pc=%h ins=%h want pc=%h ins=%h", i,
                    (i < acc_pc.size()) ? acc_pc[i] : 32'hx, (i < acc_instr.size()) ? acc_instr[i] : 32'hx,
                    32'(4 * i), mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; instrReady = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (imemReq !== 1'b0) begin fails++; $display("FAIL bp_req[%0d]: got %0b want 0", i, imemReq); end
            tests_run++; if (instr !== 32'h8C01_0000 || opCode !== 6'd35 || instrPc !== 32'h0) begin
                fails++; $display("FAIL bp_hold[%0d]: got ins=%h opc=%0d pc=%h want 8c010000/35/0", i, instr, opCode, instrPc); end
        end
        tests_run++; if (iss_log.size() != 2) begin fails++; $display("FAIL bp_issues: got %0d want 2", iss_log.size()); end
        instrReady = 1'b1;
        tick();
        tests_run++; if (acc_instr.size() != 1 || acc_instr[0] !== 32'h8C01_0000) begin
            fails++; $display("FAIL bp_first_accept: got n=%0d want 1 word 8c010000", acc_instr.size()); end
        tests_run++; if (instr !== 32'hAC02_0004 || opCode !== 6'd43 || instrPc !== 32'h4) begin
            fails++; $display("FAIL bp_second: got ins=%h opc=%0d pc=%h want ac020004/43/4", instr, opCode, instrPc); end
    endtask

    task automatic test_grant_stall();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; instrReady = 1'b1;
        repeat (3) tick();
        tests_run++; if (imemReq !== 1'b1 || imemAddr !== 32'h8) begin
            fails++; $display("FAIL stall_setup: got req=%0b addr=%h want 1/8", imemReq, imemAddr); end
        gnt_en = 1'b0; instrReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (imemReq !== 1'b1 || imemAddr !== 32'h8) begin
                fails++; $display("FAIL stall_hold[%0d]: got req=%0b addr=%h want 1/8", i, imemReq, imemAddr); end
        end
        gnt_en = 1'b1;
        tick();
        tests_run++; if (iss_log.size() != 3 || iss_log[iss_log.size() - 1] !== 32'h8 || imemAddr !== 32'hC) begin
            fails++; $display("FAIL stall_release: got n=%0d addr=%h want 3 issues, addr c", iss_log.size(), imemAddr); end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b0; instrReady = 1'b0;
        repeat (2) tick();
        redirect = 1'b1; redirectPc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        #1;
        tests_run++; if (imemReq !== 1'b0 || imemAddr !== 32'h100 || instrValid !== 1'b0) begin
            fails++; $display("FAIL flush_enter: got req=%0b addr=%h v=%0b want 0/100/0", imemReq, imemAddr, instrValid); end
        rsp_en = 1'b1;
        tick();
        tests_run++; if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
            fails++; $display("FAIL flush_drop1: got req=%0b v=%0b want 0/0", imemReq, instrValid); end
        tick();
        tests_run++; if (imemReq !== 1'b1 || imemAddr !== 32'h100 || instrValid !== 1'b0) begin
            fails++; $display("FAIL flush_exit: got req=%0b addr=%h v=%0b want 1/100/0", imemReq, imemAddr, instrValid); end
        instrReady = 1'b1;
        repeat (2) tick();
        tests_run++; if (instrValid !== 1'b1 || instrPc !== 32'h100 || instr !== 32'h1234_0100 || acc_pc.size() != 0) begin
            fails++; $display("FAIL flush_new_word: got v=%0b pc=%h ins=%h acc=%0d want 1/100/12340100/0", instrValid, instrPc, instr, acc_pc.size()); end
    endtask

    task automatic test_redirect_collision();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; instrReady = 1'b0;
        repeat (2) tick();
        instrReady = 1'b1; redirect = 1'b1; redirectPc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        #1;
        tests_run++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h200) begin
            fails++; $display("FAIL coll_after: got v=%0b req=%0b addr=%h want 0/1/200", instrValid, imemReq, imemAddr); end
        repeat (2) tick();
        tests_run++; if (instrValid !== 1'b1 || instrPc !== 32'h200 || instr !== 32'h1234_0200) begin
            fails++; $display("FAIL coll_new_word: got v=%0b pc=%h ins=%h want 1/200/12340200", instrValid, instrPc, instr); end
        tick();
        tests_run++; if (acc_pc.size() != 2 || acc_pc[0] !== 32'h0 || acc_pc[1] !== 32'h200) begin
            fails++; $display("FAIL coll_accepts: got n=%0d want 2 accepts pc 0 then 200", acc_pc.size()); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; instrReady = 1'b0;
        repeat (2) tick();
        tests_run++; if (instrValid !== 1'b1) begin fails++; $display("FAIL mrst_pre: got v=%0b want 1", instrValid); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (instrValid !== 1'b0 || imemReq !== 1'b0 || instr !== 32'h0 || instrPc !== 32'h0 || imemAddr !== 32'h0) begin
            fails++; $display("FAIL mrst_clear: got v=%0b req=%0b ins=%h pc=%h addr=%h want all 0", instrValid, imemReq, instr, instrPc, imemAddr); end
        clear_logs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        tests_run++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
            fails++; $display("FAIL mrst_restart: got req=%0b addr=%h want 1/0", imemReq, imemAddr); end
        instrReady = 1'b1;
        repeat (2) tick();
        tests_run++; if (instrValid !== 1'b1 || instrPc !== 32'h0 || instr !== 32'h8C01_0000) begin
            fails++; $display("FAIL mrst_word: got v=%0b pc=%h ins=%h want 1/0/8c010000", instrValid, instrPc, instr); end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_grant_stall();
        test_redirect_flush();
        test_redirect_collision();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

`default_nettype wire
